// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, flag bit positions and MDU state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam int FLG_DIVZ = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_UNF  = 2;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

    // What FINISH should report for the operation that just completed
    typedef enum logic [1:0] {
        KIND_MUL  = 2'b00,
        KIND_DIV  = 2'b01,
        KIND_DIVZ = 2'b10,
        KIND_INV  = 2'b11
    } mdu_kind_e;

endpackage

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - shift-add multiply / restoring divide accumulator and iteration counter
module mdu_datapath #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_cnt_zero
);

    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_is_div;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [WIDTH:0]       w_add_sum;
    logic [WIDTH:0]       w_shifted;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_rem_sub;

    // Multiply: {r_hi, r_lo} is the product register with the multiplier in r_lo.
    assign w_add_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_shifted = {r_hi, r_lo[WIDTH-1]};
    assign w_q_bit   = (w_shifted >= {1'b0, r_opnd});
    assign w_rem_sub = w_shifted[WIDTH-1:0] - r_opnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= i_is_div ? i_a : i_b;
            r_opnd   <= i_is_div ? i_b : i_a;
            r_is_div <= i_is_div;
            r_cnt    <= CNT_WIDTH'(WIDTH - 1);
        end else if (i_step) begin
            if (r_is_div) begin
                r_hi <= w_q_bit ? w_rem_sub : w_shifted[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_q_bit};
            end else begin
                r_hi <= w_add_sum[WIDTH:1];
                r_lo <= {w_add_sum[0], r_lo[WIDTH-1:1]};
            end
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_cnt_zero = (r_cnt == '0);

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide engine with start/busy/done handshake
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FLAG_WIDTH = 3,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [3:0]            ALUCon,
    input  logic [WIDTH-1:0]      DataA,
    input  logic [WIDTH-1:0]      DataB,
    input  logic                  Abort,
    output logic                  Busy,
    output logic                  Done,
    output logic [WIDTH-1:0]      Result,
    output logic [WIDTH-1:0]      Hi,
    output logic [FLAG_WIDTH-1:0] Flag
);

    logic [1:0]            r_state;
    mdu_kind_e             r_kind;
    logic [WIDTH-1:0]      r_result;
    logic [WIDTH-1:0]      r_hi;
    logic [FLAG_WIDTH-1:0] r_flag;

    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_div_zero;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_step;
    logic [WIDTH-1:0]      w_dp_hi;
    logic [WIDTH-1:0]      w_dp_lo;
    logic                  w_cnt_zero;
    logic [WIDTH-1:0]      w_fin_result;
    logic [WIDTH-1:0]      w_fin_hi;
    logic [FLAG_WIDTH-1:0] w_fin_flag;

    assign w_is_mul   = (ALUCon == ALU_MUL);
    assign w_is_div   = (ALUCon == ALU_DIV);
    assign w_div_zero = w_is_div && (DataB == '0);
    assign w_accept   = (r_state == ST_IDLE) && Start && !Abort;

    // Divide-by-zero still loads so the dividend is available for Hi in FINISH.
    assign w_load = w_accept && (w_is_mul || w_is_div);
    assign w_step = (r_state == ST_RUN) && !Abort;

    mdu_datapath #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_is_div   (w_is_div),
        .i_a        (DataA),
        .i_b        (DataB),
        .o_hi       (w_dp_hi),
        .o_lo       (w_dp_lo),
        .o_cnt_zero (w_cnt_zero)
    );

    always_comb begin
        w_fin_result = '0;
        w_fin_hi     = '0;
        w_fin_flag   = '0;
        case (r_kind)
            KIND_MUL: begin
                w_fin_result        = w_dp_lo;
                w_fin_hi            = w_dp_hi;
                w_fin_flag[FLG_OVF] = (w_dp_hi != '0);
            end
            KIND_DIV: begin
                w_fin_result = w_dp_lo;
                w_fin_hi     = w_dp_hi;
            end
            KIND_DIVZ: begin
                w_fin_result         = '1;
                w_fin_hi             = w_dp_lo;
                w_fin_flag[FLG_DIVZ] = 1'b1;
            end
            default: begin
                w_fin_result = '0;
                w_fin_hi     = '0;
                w_fin_flag   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_kind   <= KIND_INV;
            r_result <= '0;
            r_hi     <= '0;
            r_flag   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (!(w_is_mul || w_is_div)) begin
                            r_kind  <= KIND_INV;
                            r_state <= ST_FINISH;
                        end else if (w_div_zero) begin
                            r_kind  <= KIND_DIVZ;
                            r_state <= ST_FINISH;
                        end else begin
                            r_kind  <= w_is_div ? KIND_DIV : KIND_MUL;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (Abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (!Abort) begin
                        r_result <= w_fin_result;
                        r_hi     <= w_fin_hi;
                        r_flag   <= w_fin_flag;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs show the fresh result during the Done cycle; an abort in FINISH leaves the held values visible.
    assign Busy   = (r_state == ST_RUN);
    assign Done   = (r_state == ST_FINISH) && !Abort;
    assign Result = Done ? w_fin_result : r_result;
    assign Hi     = Done ? w_fin_hi     : r_hi;
    assign Flag   = Done ? w_fin_flag   : r_flag;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit
module tb_mul_div_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [3:0]  ALUCon;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] Hi;
    logic [2:0]  Flag;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [2:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    mul_div_unit #(
        .WIDTH      (32),
        .FLAG_WIDTH (3),
        .CNT_WIDTH  (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .ALUCon (ALUCon),
        .DataA  (DataA),
        .DataB  (DataB),
        .Abort  (Abort),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .Hi     (Hi),
        .Flag   (Flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] h, input logic [2:0] f);
        exp_t e;
        e.res = r;
        e.hi  = h;
        e.flg = f;
        sb_q.push_back(e);
    endtask

    // Monitor: every Done must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && Done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 result=%0h", Result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_result", Result, mon_e.res);
                chk("sb_hi", Hi, mon_e.hi);
                chk("sb_flag", Flag, mon_e.flg);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUCon = op;
        DataA  = a;
        DataB  = b;
        Start  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        ALUCon = 4'($urandom);
        DataA  = $urandom;
        DataB  = $urandom;
    endtask

    // Called at the negedge of cycle lat0 after the start edge; counts cycles until Done.
    task automatic wait_done(input string name, input int lat0, input int exp_lat, input int exp_busy);
        int lat  = lat0;
        int busy = 0;
        while (!Done && lat < 100) begin
            if (Busy) busy++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, busy, exp_busy);
        chk({name, "_busy_at_done"}, Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        Start  = 1'b0;
        Abort  = 1'b0;
        ALUCon = 4'b0000;
        DataA  = '0;
        DataB  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_result", Result, 0);
        chk("reset_hi", Hi, 0);
        chk("reset_flag", Flag, 0);
        rst_n = 1'b1;

        push(32'd42, 32'd0, 3'b000);
        issue(ALU_MUL, 32'd7, 32'd6);
        wait_done("mul7x6", 1, 33, 32);

        // Reset in the middle of a multiply
        issue(ALU_MUL, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        chk("midreset_busy_before", Busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", Busy, 0);
        chk("midreset_done", Done, 0);
        chk("midreset_result", Result, 0);
        chk("midreset_hi", Hi, 0);
        chk("midreset_flag", Flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midreset_idle_busy", Busy, 0);

        push(32'hFFFF_FFFE, 32'd1, 3'b010);
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_done("mul_ovf", 1, 33, 32);

        push(32'd0, 32'd1, 3'b010);
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_done("mul_2p32", 1, 33, 32);

        push(32'd14, 32'd2, 3'b000);
        issue(ALU_DIV, 32'd100, 32'd7);
        wait_done("div100_7", 1, 33, 32);

        push(32'h0FFF_FFFF, 32'hF, 3'b000);
        issue(ALU_DIV, 32'hFFFF_FFFF, 32'd16);
        wait_done("div_big", 1, 33, 32);

        push(32'hFFFF_FFFF, 32'd5, 3'b001);
        issue(ALU_DIV, 32'd5, 32'd0);
        wait_done("div_by_zero", 1, 1, 0);

        // Start of a DIV in cycle 5 of a running MUL must be ignored
        push(32'd7006652, 32'd0, 3'b000);
        issue(ALU_MUL, 32'd1234, 32'd5678);
        repeat (3) @(negedge clk);
        ALUCon = ALU_DIV;
        DataA  = 32'd9;
        DataB  = 32'd3;
        Start  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        wait_done("mul_ignore_start", 5, 33, 28);

        // Abort during RUN
        issue(ALU_MUL, 32'd3, 32'd3);
        repeat (19) @(negedge clk);
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        chk("abort_run_busy", Busy, 0);
        chk("abort_run_result", Result, 32'd7006652);
        chk("abort_run_flag", Flag, 3'b000);
        repeat (40) @(negedge clk);
        chk("abort_run_no_done", Done, 0);

        // Abort landing in the FINISH cycle
        issue(ALU_DIV, 32'd100, 32'd10);
        repeat (31) @(negedge clk);
        @(posedge clk);
        #1 Abort = 1'b1;
        @(negedge clk);
        chk("abort_fin_done", Done, 0);
        chk("abort_fin_result", Result, 32'd7006652);
        chk("abort_fin_busy", Busy, 0);
        @(posedge clk);
        #1 Abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_fin_held", Result, 32'd7006652);

        // Abort and Start together in IDLE
        @(negedge clk);
        ALUCon = ALU_MUL;
        DataA  = 32'd2;
        DataB  = 32'd2;
        Start  = 1'b1;
        Abort  = 1'b1;
        @(negedge clk);
        Start  = 1'b0;
        Abort  = 1'b0;
        chk("abort_start_busy", Busy, 0);
        repeat (35) @(negedge clk);
        chk("abort_start_result", Result, 32'd7006652);

        push(32'd0, 32'd0, 3'b000);
        issue(ALU_AND, 32'd5, 32'd6);
        wait_done("invalid_op", 1, 1, 0);

        repeat (3) @(negedge clk);
        chk("final_held_result", Result, 32'd0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
